player_anim_ctrl: RTL

//  Sequencer for the player sprite datapath. Tracks facing direction, walk-cycle frame and

---
 rtl/player_anim_ctrl_if.sv | 45 ++++
 rtl/player_anim_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_anim_ctrl_if.sv
// Player animation controller bus.
// Collects the frame strobe, keyboard and player-pixel inputs together with the pose and
// sprite-address outputs. The master drives the inputs (player / keyboard side) and the
// slave is the controller itself.
`timescale 1ns/1ps
interface player_anim_ctrl_if;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        is_player_in;
    logic [11:0] player_addr_in;
    logic        is_player_out;
    logic [15:0] sprite_addr;
    logic [1:0]  facing;
    logic [2:0]  anim_img;
    logic        fire;
    logic        shooting;

    // Stimulus / upstream side
    modport master (
        output frame_clk,
        output keycode,
        output is_player_in,
        output player_addr_in,
        input  is_player_out,
        input  sprite_addr,
        input  facing,
        input  anim_img,
        input  fire,
        input  shooting
    );

    // Controller side
    modport slave (
        input  frame_clk,
        input  keycode,
        input  is_player_in,
        input  player_addr_in,
        output is_player_out,
        output sprite_addr,
        output facing,
        output anim_img,
        output fire,
        output shooting
    );
endinterface

// File: rtl/player_anim_ctrl.sv
// Player sprite pose sequencer.
// On every frame tick it updates facing direction, walk-cycle image and shoot state from the
// current keycode, and emits a single-cycle fire pulse limited by a frame-counted cooldown.
// Every clock it rebases the player's local sprite address into the shared sprite ROM image
// for the current pose, one register stage behind is_player_in.
`timescale 1ns/1ps
module player_anim_ctrl #(
    parameter int NUM_WALK     = 4,     // walk images per direction; image NUM_WALK is the shoot pose
    parameter int ANIM_DIV     = 8,     // frame ticks per walk-image advance
    parameter int SHOOT_FRAMES = 6,     // frame ticks the shoot pose is held
    parameter int COOLDOWN     = 20,    // frame ticks between accepted shots
    parameter int SPRITE_WORDS = 2560   // words per sprite image
) (
    input  logic              Clk,
    input  logic              Reset,
    player_anim_ctrl_if.slave bus
);

    localparam int IMG_W  = 3;
    localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int HOLD_W = (SHOOT_FRAMES > 1) ? $clog2(SHOOT_FRAMES) : 1;
    localparam int CD_W   = $clog2(COOLDOWN + 1);

    // HID keycodes
    localparam logic [7:0] KEY_FIRE = 8'd44;
    // Direction keys packed by facing code: [0] W up, [1] S down, [2] A left, [3] D right
    localparam logic [31:0] DIR_KEY_TABLE = {8'd7, 8'd4, 8'd22, 8'd26};

    localparam logic [1:0] FACING_DOWN = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_SHOOT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              state_reg;
    logic [1:0]          facing_reg;
    logic [IMG_W-1:0]    anim_img_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [HOLD_W-1:0]   hold_reg;
    logic [CD_W-1:0]     cooldown_reg;
    logic                fire_reg;
    logic                shooting_reg;
    logic [15:0]         sprite_addr_reg;
    logic                is_player_reg;
    logic                frame_cur_reg;
    logic                frame_prev_reg;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                tick;
    logic [3:0]          dir_hit;
    logic                dir_valid;
    logic [1:0]          dir_code;
    logic                fire_key;
    logic                cooldown_expiring;
    logic                fire_accept;
    logic                walk_div_done;
    logic                walk_wrap;
    logic [15:0]         pose_base;
    logic [15:0]         sprite_addr_next;

    // frame_clk is sampled into cur, then prev; the rising edge gives a one-Clk tick.
    assign tick = frame_cur_reg & ~frame_prev_reg;

    // One comparator per direction key; at most one can match since keycode is a single byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir_decode
            assign dir_hit[gi] = (bus.keycode == DIR_KEY_TABLE[gi*8 +: 8]);
        end
    endgenerate

    assign dir_valid = |dir_hit;

    // Turn the one-hot direction match into a facing code.
    always_comb begin
        dir_code = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (dir_hit[i]) begin
                dir_code = 2'(i);
            end
        end
    end

    assign fire_key = (bus.keycode == KEY_FIRE);

    // The cooldown also counts down on the tick being evaluated, so a shot is accepted on the
    // tick where the counter runs out: a held fire key repeats exactly COOLDOWN ticks apart.
    assign cooldown_expiring = (cooldown_reg <= CD_W'(1));

    // Shots are never accepted while the shoot pose is being held.
    assign fire_accept = tick & fire_key & cooldown_expiring & (state_reg != S_SHOOT);

    assign walk_div_done = (div_reg == DIV_W'(ANIM_DIV - 1));
    assign walk_wrap     = (anim_img_reg == IMG_W'(NUM_WALK - 1));

    // Base word of the current pose image inside the shared ROM: one image block per
    // (facing, image) pair, NUM_WALK+1 images per direction.
    assign pose_base = 16'((32'(facing_reg) * 32'(NUM_WALK + 1) + 32'(anim_img_reg))
                           * 32'(SPRITE_WORDS));

    assign sprite_addr_next = pose_base + 16'(bus.player_addr_in);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Sample frame_clk for rising-edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cur_reg  <= 1'b0;
            frame_prev_reg <= 1'b0;
        end else begin
            frame_cur_reg  <= bus.frame_clk;
            frame_prev_reg <= frame_cur_reg;
        end
    end

    // Shot cooldown: reload on an accepted shot, otherwise count down to zero each tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cooldown_reg <= '0;
        end else if (tick) begin
            if (fire_accept) begin
                cooldown_reg <= CD_W'(COOLDOWN);
            end else if (cooldown_reg != '0) begin
                cooldown_reg <= cooldown_reg - CD_W'(1);
            end
        end
    end

    // Pose state machine: IDLE / WALK / SHOOT, all outputs registered, advancing on tick only.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            facing_reg   <= FACING_DOWN;
            anim_img_reg <= '0;
            div_reg      <= '0;
            hold_reg     <= '0;
            fire_reg     <= 1'b0;
            shooting_reg <= 1'b0;
        end else begin
            // fire is a single-cycle strobe; only the entry into SHOOT raises it
            fire_reg <= 1'b0;
            if (tick) begin
                case (state_reg)
                    S_IDLE: begin
                        if (dir_valid) begin
                            facing_reg   <= dir_code;
                            anim_img_reg <= '0;
                            div_reg      <= '0;
                            state_reg    <= S_WALK;
                        end else if (fire_accept) begin
                            state_reg    <= S_SHOOT;
                            fire_reg     <= 1'b1;
                            anim_img_reg <= IMG_W'(NUM_WALK);
                            hold_reg     <= HOLD_W'(SHOOT_FRAMES - 1);
                            shooting_reg <= 1'b1;
                        end else begin
                            anim_img_reg <= '0;
                        end
                    end

                    S_WALK: begin
                        if (dir_valid) begin
                            // Turning keeps the walk phase so the stride does not restart.
                            facing_reg <= dir_code;
                            if (walk_div_done) begin
                                div_reg      <= '0;
                                anim_img_reg <= walk_wrap ? '0 : anim_img_reg + IMG_W'(1);
                            end else begin
                                div_reg <= div_reg + DIV_W'(1);
                            end
                        end else if (fire_accept) begin
                            state_reg    <= S_SHOOT;
                            fire_reg     <= 1'b1;
                            anim_img_reg <= IMG_W'(NUM_WALK);
                            div_reg      <= '0;
                            hold_reg     <= HOLD_W'(SHOOT_FRAMES - 1);
                            shooting_reg <= 1'b1;
                        end else begin
                            state_reg    <= S_IDLE;
                            anim_img_reg <= '0;
                            div_reg      <= '0;
                        end
                    end

                    S_SHOOT: begin
                        // Facing is frozen; the keycode only decides where to go on exit.
                        if (hold_reg != '0) begin
                            hold_reg <= hold_reg - HOLD_W'(1);
                        end else begin
                            shooting_reg <= 1'b0;
                            anim_img_reg <= '0;
                            div_reg      <= '0;
                            if (dir_valid) begin
                                facing_reg <= dir_code;
                                state_reg  <= S_WALK;
                            end else begin
                                state_reg  <= S_IDLE;
                            end
                        end
                    end

                    default: begin
                        state_reg    <= S_IDLE;
                        anim_img_reg <= '0;
                        div_reg      <= '0;
                        shooting_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sprite address path: rebase every clock so it stays aligned with is_player_out.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sprite_addr_reg <= '0;
            is_player_reg   <= 1'b0;
        end else begin
            sprite_addr_reg <= sprite_addr_next;
            is_player_reg   <= bus.is_player_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.is_player_out = is_player_reg;
    assign bus.sprite_addr   = sprite_addr_reg;
    assign bus.facing        = facing_reg;
    assign bus.anim_img      = anim_img_reg;
    assign bus.fire          = fire_reg;
    assign bus.shooting      = shooting_reg;

endmodule
